// File: rtl/sha3_pkg.sv
// Shared constants, state encoding and byte-mask helper for the SHA3-256 unpadder.
package sha3_pkg;

  localparam int          RATE_WORDS  = 17;
  localparam int          W           = 64;
  localparam logic [7:0]  PAD_MARKER  = 8'h06;
  localparam int          PAD_END_BIT = 7;
  localparam logic [4:0]  LAST_IDX    = 5'(RATE_WORDS - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Keeps the leading byte_num bytes of a big-endian word (byte 0 = bits 63:56).
  function automatic logic [63:0] byte_mask(input logic [3:0] byte_num);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(byte_num)) m[63 - 8*i -: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/sha3_unpad_byte_find.sv
// Combinational search for the highest-position (last in big-endian order) nonzero byte of a word.
module sha3_unpad_byte_find
  import sha3_pkg::*;
(
  input  logic [63:0] word,
  input  logic        mask_end,
  output logic        found,
  output logic [2:0]  byte_idx,
  output logic [7:0]  byte_val
);

  logic [63:0] word_m;
  logic [7:0]  bytes [8];
  logic [7:0]  nz;

  // The final 0x80 pad bit belongs to the padding, so it must not count as data.
  always_comb begin
    word_m = word;
    if (mask_end) word_m[PAD_END_BIT] = 1'b0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte
      assign bytes[gi] = word_m[63 - 8*gi -: 8];
      assign nz[gi]    = |word_m[63 - 8*gi -: 8];
    end
  endgenerate

  always_comb begin
    found    = 1'b0;
    byte_idx = 3'd0;
    byte_val = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (nz[i]) begin
        found    = 1'b1;
        byte_idx = 3'(i);
        byte_val = bytes[i];
      end
    end
  end

endmodule

// File: rtl/sha3_unpadder.sv
// SHA3-256 pad10*1 stripper: buffers a 17-word rate block, locates the 0x06 marker, re-emits message words.
// Optional msg_len output enabled by defining SHA3_UNPAD_MSG_LEN_EN.
module sha3_unpadder
  import sha3_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  output logic [63:0] out,
  output logic [3:0]  out_byte_num,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        pad_err
`ifdef SHA3_UNPAD_MSG_LEN_EN
  ,
  output logic [31:0] msg_len
`endif
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  scan_idx_q, scan_idx_d;
  logic [4:0]  rd_idx_q, rd_idx_d;
  logic [4:0]  n_out_q, n_out_d;
  logic        final_q, final_d;
  logic [2:0]  last_bytes_q, last_bytes_d;
  logic        pad_err_q, pad_err_d;
  logic [31:0] msg_len_q, msg_len_d;

  logic [63:0] blk_q [RATE_WORDS];
  logic        blk_we;

  logic        find_found;
  logic [2:0]  find_idx;
  logic [7:0]  find_val;
  logic        is_last_word;
  logic        err;

  sha3_unpad_byte_find u_find (
    .word     (blk_q[scan_idx_q]),
    .mask_end (scan_idx_q == LAST_IDX),
    .found    (find_found),
    .byte_idx (find_idx),
    .byte_val (find_val)
  );

  always_ff @(posedge clk) begin
    if (blk_we) blk_q[cnt_q] <= in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      scan_idx_q   <= '0;
      rd_idx_q     <= '0;
      n_out_q      <= '0;
      final_q      <= 1'b0;
      last_bytes_q <= '0;
      pad_err_q    <= 1'b0;
      msg_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scan_idx_q   <= scan_idx_d;
      rd_idx_q     <= rd_idx_d;
      n_out_q      <= n_out_d;
      final_q      <= final_d;
      last_bytes_q <= last_bytes_d;
      pad_err_q    <= pad_err_d;
      msg_len_q    <= msg_len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    scan_idx_d   = scan_idx_q;
    rd_idx_d     = rd_idx_q;
    n_out_d      = n_out_q;
    final_d      = final_q;
    last_bytes_d = last_bytes_q;
    pad_err_d    = 1'b0;
    msg_len_d    = msg_len_q;
    blk_we       = 1'b0;
    err          = 1'b0;

    in_ready     = (state_q == FILL);
    out_valid    = (state_q == DRAIN);
    is_last_word = (rd_idx_q == n_out_q - 5'd1);
    out_last     = out_valid && final_q && is_last_word;
    if (!out_valid)                  out_byte_num = 4'd0;
    else if (final_q && is_last_word) out_byte_num = {1'b0, last_bytes_q};
    else                             out_byte_num = 4'd8;
    out = blk_q[rd_idx_q] & byte_mask(out_byte_num);

    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          blk_we = 1'b1;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == LAST_IDX) begin
            cnt_d    = '0;
            rd_idx_d = '0;
            if (in_last) begin
              state_d    = SCAN;
              scan_idx_d = LAST_IDX;
            end else begin
              state_d = DRAIN;
              n_out_d = 5'(RATE_WORDS);
              final_d = 1'b0;
            end
          end
        end
      end
      SCAN: begin
        // Word 16 is visited first; without its end bit the block cannot be a valid final block.
        if (scan_idx_q == LAST_IDX && !blk_q[LAST_IDX][PAD_END_BIT]) begin
          err = 1'b1;
        end else if (find_found) begin
          if (find_val == PAD_MARKER) begin
            state_d      = DRAIN;
            n_out_d      = scan_idx_q + 5'd1;
            last_bytes_d = find_idx;
            final_d      = 1'b1;
            rd_idx_d     = '0;
          end else begin
            err = 1'b1;
          end
        end else if (scan_idx_q == 5'd0) begin
          err = 1'b1;
        end else begin
          scan_idx_d = scan_idx_q - 5'd1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          msg_len_d = out_last ? 32'd0 : msg_len_q + {28'd0, out_byte_num};
          if (is_last_word) begin
            state_d = FILL;
            cnt_d   = '0;
          end else begin
            rd_idx_d = rd_idx_q + 5'd1;
          end
        end
      end
      default: state_d = FILL;
    endcase

    if (err) begin
      pad_err_d = 1'b1;
      state_d   = FILL;
      cnt_d     = '0;
      msg_len_d = '0;
    end

    pad_err = pad_err_q;
  end

`ifdef SHA3_UNPAD_MSG_LEN_EN
  assign msg_len = msg_len_q + {28'd0, out_byte_num};
`endif

endmodule

// File: tb/tb_sha3_unpadder.sv
// Directed, table-driven bench for sha3_unpadder (block decode, malformed blocks, backpressure, reset).
module tb_sha3_unpadder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] din;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [63:0] dout;
  logic [3:0]  out_byte_num;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        pad_err;
`ifdef SHA3_UNPAD_MSG_LEN_EN
  logic [31:0] msg_len;
`endif

  sha3_unpadder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in           (din),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .out          (dout),
    .out_byte_num (out_byte_num),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .pad_err      (pad_err)
`ifdef SHA3_UNPAD_MSG_LEN_EN
    ,
    .msg_len      (msg_len)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0][63:0] blk;
    logic              fin;
    logic              err;
    logic [4:0]        n_exp;
    logic [63:0]       last_data;
    logic [3:0]        last_bn;
    logic [31:0]       exp_len;
  } case_t;

  localparam int NCASES = 8;
  case_t cases [NCASES];
  string names [NCASES];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_word(input logic [63:0] d, input logic l);
    int t;
    t = 0;
    @(negedge clk);
    din      = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [16:0][63:0] blk, input logic fin);
    for (int w = 0; w < 17; w++) send_word(blk[w], (w == 16) ? fin : ~fin);
  endtask

  task automatic wait_valid(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) check({name, "_valid_timeout"}, {127'd0, out_valid}, 128'd1);
  endtask

  task automatic run_case(input int ci);
    case_t       c;
    int          got, errs, cyc;
    logic [63:0] ed;
    logic [3:0]  eb;
    logic        el;
    c    = cases[ci];
    got  = 0;
    errs = 0;
    cyc  = 0;
    out_ready = 1'b1;
    send_block(c.blk, c.fin);
    while (cyc < 40 && !(!c.err && got == int'(c.n_exp))) begin
      @(negedge clk);
      cyc++;
      if (pad_err) errs++;
      if (out_valid) begin
        if (got == int'(c.n_exp) - 1) begin
          ed = c.last_data; eb = c.last_bn; el = c.fin;
        end else begin
          ed = c.blk[got]; eb = 4'd8; el = 1'b0;
        end
        check($sformatf("%s_w%0d", names[ci], got), {dout, out_byte_num, out_last}, {ed, eb, el});
`ifdef SHA3_UNPAD_MSG_LEN_EN
        if (out_last) check({names[ci], "_msg_len"}, {96'd0, msg_len}, {96'd0, c.exp_len});
`endif
        got++;
      end
    end
    check({names[ci], "_nwords"}, 128'(got), 128'(c.n_exp));
    check({names[ci], "_pad_err"}, 128'(errs), c.err ? 128'd1 : 128'd0);
    @(negedge clk);
    check({names[ci], "_idle"}, {126'd0, in_ready, out_valid}, {126'd0, 1'b1, 1'b0});
    $display("block %s: %0d words out, %0d pad_err pulses", names[ci], got, errs);
  endtask

  logic [16:0][63:0] seq_blk;

  initial begin
    reset_n   = 1'b0;
    din       = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < NCASES; i++) cases[i] = '0;

    names[0] = "final_p3";
    cases[0].blk[0] = 64'h1234560600000000; cases[0].blk[16] = 64'h80;
    cases[0].fin = 1; cases[0].n_exp = 1; cases[0].last_data = 64'h1234560000000000;
    cases[0].last_bn = 3; cases[0].exp_len = 3;

    names[1] = "final_86";
    for (int i = 0; i < 16; i++) cases[1].blk[i] = 64'hA5A5A5A5A5A5A5A5;
    cases[1].blk[16] = 64'h1234567890ABCD86;
    cases[1].fin = 1; cases[1].n_exp = 17; cases[1].last_data = 64'h1234567890ABCD00;
    cases[1].last_bn = 7; cases[1].exp_len = 135;

    names[2] = "final_p8";
    cases[2].blk[0] = 64'h1111111111111111; cases[2].blk[1] = 64'h0600000000000000;
    cases[2].blk[16] = 64'h80;
    cases[2].fin = 1; cases[2].n_exp = 2; cases[2].last_data = 64'h0;
    cases[2].last_bn = 0; cases[2].exp_len = 8;

    names[3] = "final_empty";
    cases[3].blk[0] = 64'h0600000000000000; cases[3].blk[16] = 64'h80;
    cases[3].fin = 1; cases[3].n_exp = 1; cases[3].last_data = 64'h0;
    cases[3].last_bn = 0; cases[3].exp_len = 0;

    names[4] = "final_p133";
    for (int i = 0; i < 16; i++) cases[4].blk[i] = 64'h0123456789ABCDEF;
    cases[4].blk[16] = 64'hDEADBEEFCA060080;
    cases[4].fin = 1; cases[4].n_exp = 17; cases[4].last_data = 64'hDEADBEEFCA000000;
    cases[4].last_bn = 5; cases[4].exp_len = 133;

    names[5] = "err_no_end";
    cases[5].fin = 1; cases[5].err = 1;

    names[6] = "err_marker07";
    cases[6].blk[0] = 64'h0700000000000000; cases[6].blk[16] = 64'h80;
    cases[6].fin = 1; cases[6].err = 1;

    names[7] = "nonfinal";
    for (int i = 0; i < 17; i++) cases[7].blk[i] = 64'(i + 1);
    cases[7].fin = 0; cases[7].n_exp = 17; cases[7].last_data = 64'h11; cases[7].last_bn = 8;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_state", {dout, out_byte_num, out_valid, out_last, pad_err, in_ready},
          {64'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
`ifdef SHA3_UNPAD_MSG_LEN_EN
    check("reset_msg_len", {96'd0, msg_len}, 128'd0);
`endif

    for (int i = 0; i < NCASES; i++) run_case(i);

    // Backpressure: stall on word 3 of a non-final block for five cycles.
    for (int i = 0; i < 17; i++) seq_blk[i] = 64'(i + 1);
    out_ready = 1'b1;
    send_block(seq_blk, 1'b0);
    wait_valid("bp");
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_w%0d", k), {dout, out_byte_num, out_last}, {64'(k + 1), 4'd8, 1'b0});
      @(negedge clk);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", k), {out_valid, dout, out_byte_num, out_last},
            {1'b1, 64'h4, 4'd8, 1'b0});
    end
    out_ready = 1'b1;
    for (int k = 3; k < 17; k++) begin
      check($sformatf("bp_w%0d", k), {out_valid, dout, out_byte_num, out_last},
            {1'b1, 64'(k + 1), 4'd8, 1'b0});
      @(negedge clk);
    end
    check("bp_done", {126'd0, in_ready, out_valid}, {126'd0, 1'b1, 1'b0});
    $display("backpressure sequence: 17 words out with 5-cycle stall");

    // Reset in the middle of DRAIN.
    send_block(seq_blk, 1'b0);
    wait_valid("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_mid_drain", {dout, out_byte_num, out_valid, out_last, in_ready},
          {64'h0, 4'd0, 1'b0, 1'b0, 1'b1});
`ifdef SHA3_UNPAD_MSG_LEN_EN
    check("rst_msg_len", {96'd0, msg_len}, 128'd0);
`endif
    $display("reset sequence: DRAIN aborted");
    run_case(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sha3_unpadder.md
Name: sha3_unpadder

Overview:
- Receive side of SHA3-256 message padding; decoder counterpart of the padder.
- Accepts padded rate blocks as 17 x 64-bit words and strips the pad10*1 padding (0x06 … 0x80, or a single combined 0x86 byte).
- Re-emits the original message as 64-bit words with a per-word byte count.
- Sits between the block link and the message consumer in loopback/verification datapaths.

Parameters:
- RATE_WORDS, 17, number of 64-bit words per rate block (1088 bits).
- W, 64, word width in bits; bytes are big-endian within a word (byte 0 = bits 63:56).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- in  in  64  padded block word.
- in_valid  in  1  `in` is valid.
- in_ready  out  1  unpadder can accept a word; high only in FILL.
- in_last  in  1  block is the final block of the message; sampled only on word index 16.
- out  out  64  message word; bytes beyond out_byte_num are forced to 0.
- out_byte_num  out  4  valid bytes in `out`, range 0..8.
- out_valid  out  1  `out` is valid.
- out_ready  in  1  consumer accepts `out`.
- out_last  out  1  last word of the message.
- pad_err  out  1  one-cycle pulse: final block is malformed.

Behaviour:
- Reset values:
  - out = 0, out_byte_num = 0, out_valid = 0, out_last = 0, pad_err = 0.
  - State = FILL, so in_ready = 1 on the first cycle after reset.
  - Word counter = 0, message length counter = 0.
- Accept/transfer rules:
  - An input word is accepted when in_valid && in_ready.
  - An output word transfers when out_valid && out_ready.
- FILL:
  - Each accepted word is stored at buf[cnt]; cnt increments.
  - On the accept of word 16, in_last is latched. in_last is ignored on all other words.
  - If in_last = 0: go to DRAIN with n_out = 17, all words byte_num 8.
  - If in_last = 1: go to SCAN.
- SCAN (in_ready = 0; one word examined per cycle, index 16 down to 0):
  - Entry cycle: if buf[16][7] = 0, assert pad_err and go to FILL.
  - Otherwise, treat buf[16][7] as cleared and find the highest-position nonzero byte in the block.
  - If that byte is not 8'h06: pad_err, then FILL.
  - If no nonzero byte remains after word 0: pad_err, then FILL.
  - If the marker is at byte position p (0..135): n_out = floor(p/8) + 1, then go to DRAIN.
  - SCAN latency = 16 − k + 1 cycles, where k is the index of the word containing the marker.
  - The per-word byte search is combinational.
- DRAIN:
  - Emit buf[0..n_out−1] in order; advance only on transfer.
  - out and all flags hold stable while out_ready = 0.
  - Final block only:
    - Words before the last carry byte_num 8.
    - The last word carries byte_num = p mod 8, masked, with out_last = 1.
    - If p mod 8 = 0, an extra word of 0 with byte_num 0 and out_last = 1 is emitted.
  - For non-final blocks, out_last = 0 on every word.
  - After the last transfer, go to FILL with cnt = 0. A new input is accepted no earlier than the next cycle.
- Boundaries:
  - p = 0 (empty final block): exactly one word 0, byte_num 0, out_last = 1.
  - A combined 0x86 at byte 135: p = 135, producing 16 full words plus a 7-byte last word.
  - On pad_err, no output words are produced for that block; buffered data is discarded.
  - reset_n low in any state (including mid-DRAIN or mid-SCAN) aborts the block; reset values apply next cycle.

Optional Feature:
- Macro: SHA3_UNPAD_MSG_LEN_EN.
- When defined:
  - Adds output msg_len[31:0]: a running count of message bytes transferred.
  - Valid while out_valid && out_last.
  - Clears after the out_last transfer, on pad_err, and on reset.
  - Wraps modulo 2^32.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package sha3_pkg:
  - RATE_WORDS, PAD_MARKER = 8'h06, PAD_END_BIT = 7, state enum {FILL, SCAN, DRAIN}.
  - Byte-mask function byte_num → 64-bit mask.
- One sub-module sha3_unpad_byte_find:
  - Combinational.
  - Inputs: 64-bit word, mask_end flag.
  - Outputs: found, byte index of the highest-position nonzero byte (0..7), that byte's value.

Test Plan:
- Non-final block, words 64'h1..64'h11, in_last = 0 → 17 outputs equal to inputs, byte_num 8, out_last = 0.
- Final block:
  - Stimulus: W0 = 64'h1234560600000000, W1..W15 = 0, W16 = 64'h80.
  - Response: one output 64'h1234560000000000, byte_num 3, out_last = 1; msg_len = 3 with the macro defined.
- Final block:
  - Stimulus: W0..W15 = 64'hA5A5A5A5A5A5A5A5, W16 = 64'h1234567890ABCD86.
  - Response: 16 words byte_num 8, then 64'h1234567890ABCD00 with byte_num 7, out_last = 1 (135 bytes).
- Final block:
  - Stimulus: W0 = 64'h1111111111111111, W1 = 64'h0600000000000000, rest 0, W16 = 64'h80.
  - Response: W0 with byte_num 8, then 0 with byte_num 0, out_last = 1.
- Malformed blocks:
  - W16 = 64'h0 → pad_err pulses once, no out_valid, in_ready returns to 1.
  - Marker byte 8'h07 → pad_err.
- Backpressure and reset:
  - Hold out_ready = 0 for 5 cycles mid-DRAIN → out and flags stay stable.
  - reset_n = 0 for one cycle mid-DRAIN → out_valid = 0, in_ready = 1 on the following cycle.
